// File: rtl/iq_pkg.sv
// ---------------------------------------------------------------------------
// iq_pkg
// Shared types and helpers for the age-ordered issue queue.
//   IQ_INST_ID_BITS  : default instruction tag width
//   IQ_PRN_BITS      : default physical register number width
//   IQ_MAX_OPERANDS  : default operand slots per instruction
//   iq_entry_t       : one queue entry (tag, encoding, pc, operand state)
//   entry_ready()    : true when an entry is valid and all used operands
//                      are ready
// The entry struct is sized from these defaults, so the queue top must be
// instantiated with matching tag/PRN/operand widths.
// ---------------------------------------------------------------------------
package iq_pkg;

  localparam int IQ_INST_ID_BITS = 6;
  localparam int IQ_PRN_BITS     = 6;
  localparam int IQ_MAX_OPERANDS = 3;

  typedef struct packed {
    logic                                         valid;
    logic [IQ_INST_ID_BITS-1:0]                   inst_id;
    logic [31:0]                                  inst;
    logic [63:0]                                  pc;
    logic [IQ_MAX_OPERANDS-1:0]                   op_valid;
    logic [IQ_MAX_OPERANDS-1:0]                   op_ready;
    logic [IQ_MAX_OPERANDS-1:0][IQ_PRN_BITS-1:0]  op_prn;
    logic [IQ_MAX_OPERANDS-1:0][IQ_PRN_BITS-1:0]  out_prn;
  } iq_entry_t;

  // An unused operand slot never blocks issue, hence the ~op_valid term.
  function automatic logic entry_ready(input iq_entry_t e);
    return e.valid && (&(e.op_ready | ~e.op_valid));
  endfunction

endpackage

// File: rtl/iq_age_matrix.sv
// ---------------------------------------------------------------------------
// iq_age_matrix
// Relative-age tracker for the issue queue. older[i][j]=1 means entry i
// was inserted before entry j. Produces a one-hot grant for the requesting
// entry that no other requester is older than.
//   clk, rst   : clock, synchronous active-high reset
//   valid      : current valid vector of the queue
//   ins_en     : an insert happens at this edge
//   ins_slot   : slot being written by the insert
//   req        : request vector (ready entries, or valid entries in order mode)
//   grant      : one-hot oldest requester
//   has_grant  : any requester granted
// ---------------------------------------------------------------------------
module iq_age_matrix #(
  parameter int QUEUE_SIZE = 8,
  parameter int SLOT_BITS  = $clog2(QUEUE_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [QUEUE_SIZE-1:0] valid,
  input  logic                  ins_en,
  input  logic [SLOT_BITS-1:0]  ins_slot,
  input  logic [QUEUE_SIZE-1:0] req,
  output logic [QUEUE_SIZE-1:0] grant,
  output logic                  has_grant
);

  logic [QUEUE_SIZE-1:0] older [QUEUE_SIZE];
  logic [QUEUE_SIZE-1:0] blocked;

  // A newly inserted entry is younger than everything currently valid:
  // clear its row, and set its column from the valid vector. Bits left over
  // from freed slots are harmless because freed slots never request.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < QUEUE_SIZE; i++) begin
        older[i] <= '0;
      end
    end else if (ins_en) begin
      for (int i = 0; i < QUEUE_SIZE; i++) begin
        older[ins_slot][i] <= 1'b0;
        older[i][ins_slot] <= valid[i];
      end
    end
  end

  // An entry wins when no other requester is older than it. Among valid
  // entries the matrix is a strict total order, so at most one wins.
  always_comb begin
    blocked = '0;
    for (int i = 0; i < QUEUE_SIZE; i++) begin
      for (int j = 0; j < QUEUE_SIZE; j++) begin
        if (req[j] && older[j][i]) begin
          blocked[i] = 1'b1;
        end
      end
    end
    grant     = req & ~blocked;
    has_grant = |grant;
  end

endmodule

// File: rtl/age_issue_queue.sv
// ---------------------------------------------------------------------------
// age_issue_queue
// Out-of-order issue queue between the renamer and one functional unit.
// Accepts one instruction per cycle, wakes operands from writeback
// broadcasts (including in the insert cycle), selects the oldest ready entry
// (or strictly the oldest valid entry when IN_ORDER=1), reads operands from
// the PRF at the fire edge and presents a registered FU payload.
//   clk, rst                 : clock, synchronous active-high reset
//   inst_valid / queue_ready : insert handshake
//   inst_id, raw_instr, instr_pc, prn_input*, prn_output : inserted instr
//   wb_valid, wb_prn         : wakeup broadcasts
//   flush                    : discard all entries and any pending issue
//   fu_ready                 : FU accepts an instruction this cycle
//   prf_read_enable/prn      : PRF read request for the selected entry
//   prf_op                   : combinational PRF read data
//   issue_*                  : registered payload, issue_valid one-cycle pulse
//   occupancy                : number of valid entries
// ---------------------------------------------------------------------------
module age_issue_queue
  import iq_pkg::*;
#(
  parameter int INST_ID_BITS = IQ_INST_ID_BITS,
  parameter int PRN_BITS     = IQ_PRN_BITS,
  parameter int MAX_OPERANDS = IQ_MAX_OPERANDS,
  parameter int QUEUE_SIZE   = 8,
  parameter int WB_PORTS     = 4,
  parameter bit IN_ORDER     = 1'b0,
  localparam int SLOT_BITS   = $clog2(QUEUE_SIZE),
  localparam int OCC_BITS    = $clog2(QUEUE_SIZE + 1)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    inst_valid,
  output logic                                    queue_ready,
  input  logic [INST_ID_BITS-1:0]                 inst_id,
  input  logic [31:0]                             raw_instr,
  input  logic [63:0]                             instr_pc,
  input  logic [MAX_OPERANDS-1:0]                 prn_input_valid,
  input  logic [MAX_OPERANDS-1:0]                 prn_input_ready,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]   prn_input,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]   prn_output,
  input  logic [WB_PORTS-1:0]                     wb_valid,
  input  logic [WB_PORTS-1:0][PRN_BITS-1:0]       wb_prn,
  input  logic                                    flush,
  input  logic                                    fu_ready,
  output logic [MAX_OPERANDS-1:0]                 prf_read_enable,
  output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]   prf_read_prn,
  input  logic [MAX_OPERANDS-1:0][63:0]           prf_op,
  output logic                                    issue_valid,
  output logic [INST_ID_BITS-1:0]                 issue_inst_id,
  output logic [31:0]                             issue_inst,
  output logic [63:0]                             issue_pc,
  output logic [MAX_OPERANDS-1:0][63:0]           issue_op,
  output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]   issue_out_prn,
  output logic [OCC_BITS-1:0]                     occupancy
);

  iq_entry_t                                  entries [QUEUE_SIZE];
  iq_entry_t                                  new_entry;
  logic [QUEUE_SIZE-1:0]                      valid_vec;
  logic [QUEUE_SIZE-1:0]                      ready_vec;
  logic [QUEUE_SIZE-1:0]                      req_vec;
  logic [QUEUE_SIZE-1:0]                      grant;
  logic [QUEUE_SIZE-1:0]                      sel_vec;
  logic                                       has_grant;
  logic                                       has_ready;
  logic [SLOT_BITS-1:0]                       ins_slot;
  logic                                       slot_found;
  logic                                       insert_fire;
  logic                                       issue_fire;
  logic [MAX_OPERANDS-1:0]                    bypass_hit;
  logic [QUEUE_SIZE-1:0][MAX_OPERANDS-1:0]    wake_hit;
  logic [INST_ID_BITS-1:0]                    sel_id;
  logic [31:0]                                sel_inst;
  logic [63:0]                                sel_pc;
  logic [MAX_OPERANDS-1:0]                    sel_op_valid;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]      sel_op_prn;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]      sel_out_prn;

  // Queue status: valid/ready vectors, lowest free slot, occupancy count.
  always_comb begin
    ins_slot   = '0;
    slot_found = 1'b0;
    occupancy  = '0;
    for (int i = 0; i < QUEUE_SIZE; i++) begin
      valid_vec[i] = entries[i].valid;
      ready_vec[i] = entry_ready(entries[i]);
      occupancy    = occupancy + OCC_BITS'(entries[i].valid);
      if (!entries[i].valid && !slot_found) begin
        ins_slot   = SLOT_BITS'(i);
        slot_found = 1'b1;
      end
    end
    queue_ready = ~&valid_vec;
  end

  // Broadcast matching is all-ports against all-operands, both for the
  // instruction being inserted and for every resident entry.
  always_comb begin
    bypass_hit = '0;
    wake_hit   = '0;
    for (int j = 0; j < MAX_OPERANDS; j++) begin
      for (int k = 0; k < WB_PORTS; k++) begin
        if (wb_valid[k] && (wb_prn[k] == prn_input[j])) begin
          bypass_hit[j] = 1'b1;
        end
        for (int i = 0; i < QUEUE_SIZE; i++) begin
          if (wb_valid[k] && (wb_prn[k] == entries[i].op_prn[j])) begin
            wake_hit[i][j] = 1'b1;
          end
        end
      end
    end
  end

  // Entry image written on insert, with same-cycle wakeups folded in.
  always_comb begin
    new_entry          = '0;
    new_entry.valid    = 1'b1;
    new_entry.inst_id  = inst_id;
    new_entry.inst     = raw_instr;
    new_entry.pc       = instr_pc;
    new_entry.op_valid = prn_input_valid;
    new_entry.op_ready = prn_input_ready | bypass_hit;
    new_entry.op_prn   = prn_input;
    new_entry.out_prn  = prn_output;
  end

  // In order mode the matrix picks the oldest valid entry and the issue
  // only proceeds when that particular entry is ready.
  always_comb begin
    req_vec     = IN_ORDER ? valid_vec : ready_vec;
    sel_vec     = grant & ready_vec;
    has_ready   = has_grant && (|sel_vec);
    insert_fire = inst_valid && queue_ready && !flush;
    issue_fire  = fu_ready && has_ready && !flush;
  end

  iq_age_matrix #(
    .QUEUE_SIZE (QUEUE_SIZE),
    .SLOT_BITS  (SLOT_BITS)
  ) u_age_matrix (
    .clk       (clk),
    .rst       (rst),
    .valid     (valid_vec),
    .ins_en    (insert_fire),
    .ins_slot  (ins_slot),
    .req       (req_vec),
    .grant     (grant),
    .has_grant (has_grant)
  );

  // One-hot mux of the selected entry; everything reads as zero when no
  // entry is selected, which also zeroes the PRF read enables.
  always_comb begin
    sel_id       = '0;
    sel_inst     = '0;
    sel_pc       = '0;
    sel_op_valid = '0;
    sel_op_prn   = '0;
    sel_out_prn  = '0;
    for (int i = 0; i < QUEUE_SIZE; i++) begin
      if (sel_vec[i]) begin
        sel_id       = entries[i].inst_id;
        sel_inst     = entries[i].inst;
        sel_pc       = entries[i].pc;
        sel_op_valid = entries[i].op_valid;
        sel_op_prn   = entries[i].op_prn;
        sel_out_prn  = entries[i].out_prn;
      end
    end
    prf_read_enable = sel_op_valid;
    prf_read_prn    = sel_op_prn;
  end

  // Entry state and the registered FU payload. Flush beats insert, issue
  // and wakeup; a wakeup on the issuing entry is lost because the entry is
  // freed at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < QUEUE_SIZE; i++) begin
        entries[i] <= '0;
      end
      issue_valid   <= 1'b0;
      issue_inst_id <= '0;
      issue_inst    <= '0;
      issue_pc      <= '0;
      issue_op      <= '0;
      issue_out_prn <= '0;
    end else if (flush) begin
      for (int i = 0; i < QUEUE_SIZE; i++) begin
        entries[i].valid <= 1'b0;
      end
      issue_valid <= 1'b0;
    end else begin
      for (int i = 0; i < QUEUE_SIZE; i++) begin
        if (entries[i].valid) begin
          entries[i].op_ready <= entries[i].op_ready | (wake_hit[i] & entries[i].op_valid);
        end
        if (issue_fire && sel_vec[i]) begin
          entries[i].valid <= 1'b0;
        end
      end
      if (insert_fire) begin
        entries[ins_slot] <= new_entry;
      end
      issue_valid <= issue_fire;
      if (issue_fire) begin
        issue_inst_id <= sel_id;
        issue_inst    <= sel_inst;
        issue_pc      <= sel_pc;
        issue_op      <= prf_op;
        issue_out_prn <= sel_out_prn;
      end
    end
  end

endmodule

// File: tb/tb_age_issue_queue.sv
// ---------------------------------------------------------------------------
// tb_age_issue_queue
// Two queue instances share the instruction/broadcast/flush buses: dut runs
// out of order, dut_io runs with IN_ORDER=1; each has its own inst_valid and
// fu_ready. Expected issues are pushed into per-instance queues and a
// monitor pops and compares whenever issue_valid is seen.
// ---------------------------------------------------------------------------
module tb_age_issue_queue;

  localparam int ID_B  = 6;
  localparam int PRN_B = 6;
  localparam int NOPS  = 3;
  localparam int QS    = 8;
  localparam int WBP   = 4;
  localparam int OCC_B = $clog2(QS + 1);

  typedef struct {
    logic [ID_B-1:0]  id;
    logic [31:0]      inst;
    logic [63:0]      pc;
    logic [63:0]      op0;
    logic [PRN_B-1:0] dst0;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  logic [ID_B-1:0]              inst_id;
  logic [31:0]                  raw_instr;
  logic [63:0]                  instr_pc;
  logic [NOPS-1:0]              prn_input_valid;
  logic [NOPS-1:0]              prn_input_ready;
  logic [NOPS-1:0][PRN_B-1:0]   prn_input;
  logic [NOPS-1:0][PRN_B-1:0]   prn_output;
  logic [WBP-1:0]               wb_valid;
  logic [WBP-1:0][PRN_B-1:0]    wb_prn;
  logic                         flush;

  logic                         inst_valid, fu_ready, queue_ready, issue_valid;
  logic [NOPS-1:0]              prf_read_enable;
  logic [NOPS-1:0][PRN_B-1:0]   prf_read_prn, issue_out_prn;
  logic [NOPS-1:0][63:0]        prf_op, issue_op;
  logic [ID_B-1:0]              issue_inst_id;
  logic [31:0]                  issue_inst;
  logic [63:0]                  issue_pc;
  logic [OCC_B-1:0]             occupancy;

  logic                         inst_valid_io, fu_ready_io, queue_ready_io, issue_valid_io;
  logic [NOPS-1:0]              prf_read_enable_io;
  logic [NOPS-1:0][PRN_B-1:0]   prf_read_prn_io, issue_out_prn_io;
  logic [NOPS-1:0][63:0]        prf_op_io, issue_op_io;
  logic [ID_B-1:0]              issue_inst_id_io;
  logic [31:0]                  issue_inst_io;
  logic [63:0]                  issue_pc_io;
  logic [OCC_B-1:0]             occupancy_io;

  int   checks   = 0;
  int   failures = 0;
  exp_t sbq[$];
  exp_t sbq_io[$];

  age_issue_queue #(
    .INST_ID_BITS(ID_B), .PRN_BITS(PRN_B), .MAX_OPERANDS(NOPS),
    .QUEUE_SIZE(QS), .WB_PORTS(WBP), .IN_ORDER(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .queue_ready(queue_ready),
    .inst_id(inst_id), .raw_instr(raw_instr), .instr_pc(instr_pc),
    .prn_input_valid(prn_input_valid), .prn_input_ready(prn_input_ready),
    .prn_input(prn_input), .prn_output(prn_output),
    .wb_valid(wb_valid), .wb_prn(wb_prn), .flush(flush), .fu_ready(fu_ready),
    .prf_read_enable(prf_read_enable), .prf_read_prn(prf_read_prn), .prf_op(prf_op),
    .issue_valid(issue_valid), .issue_inst_id(issue_inst_id), .issue_inst(issue_inst),
    .issue_pc(issue_pc), .issue_op(issue_op), .issue_out_prn(issue_out_prn),
    .occupancy(occupancy)
  );

  age_issue_queue #(
    .INST_ID_BITS(ID_B), .PRN_BITS(PRN_B), .MAX_OPERANDS(NOPS),
    .QUEUE_SIZE(QS), .WB_PORTS(WBP), .IN_ORDER(1'b1)
  ) dut_io (
    .clk(clk), .rst(rst), .inst_valid(inst_valid_io), .queue_ready(queue_ready_io),
    .inst_id(inst_id), .raw_instr(raw_instr), .instr_pc(instr_pc),
    .prn_input_valid(prn_input_valid), .prn_input_ready(prn_input_ready),
    .prn_input(prn_input), .prn_output(prn_output),
    .wb_valid(wb_valid), .wb_prn(wb_prn), .flush(flush), .fu_ready(fu_ready_io),
    .prf_read_enable(prf_read_enable_io), .prf_read_prn(prf_read_prn_io), .prf_op(prf_op_io),
    .issue_valid(issue_valid_io), .issue_inst_id(issue_inst_id_io), .issue_inst(issue_inst_io),
    .issue_pc(issue_pc_io), .issue_op(issue_op_io), .issue_out_prn(issue_out_prn_io),
    .occupancy(occupancy_io)
  );

  always #5 clk = ~clk;

  // Register file model: contents are a fixed function of the address.
  function automatic logic [63:0] prfData(input logic [PRN_B-1:0] p);
    logic [63:0] v;
    v = {58'd0, p};
    return 64'hFACE_0000_0000_0000 | v | (v << 32);
  endfunction

  function automatic logic [63:0] pcOf(input logic [ID_B-1:0] id);
    return 64'h1000 + ({58'd0, id} << 2);
  endfunction

  function automatic logic [31:0] instOf(input logic [ID_B-1:0] id);
    return 32'hDEAD_0000 | {26'd0, id};
  endfunction

  function automatic logic [PRN_B-1:0] dstOf(input logic [ID_B-1:0] id);
    return id + 6'd20;
  endfunction

  // Combinational PRF read ports, one per instance.
  always_comb begin
    for (int j = 0; j < NOPS; j++) begin
      prf_op[j]    = prfData(prf_read_prn[j]);
      prf_op_io[j] = prfData(prf_read_prn_io[j]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic expectIssue(input bit io, input logic [ID_B-1:0] id,
                             input logic [PRN_B-1:0] prn);
    exp_t e;
    e.id   = id;
    e.inst = instOf(id);
    e.pc   = pcOf(id);
    e.op0  = prfData(prn);
    e.dst0 = dstOf(id);
    if (io) sbq_io.push_back(e);
    else    sbq.push_back(e);
  endtask

  // One-cycle insert request. Only operand 0 is used; operand 1 carries an
  // unready PRN that must be ignored because its valid bit is clear.
  task automatic applyStimulus(input bit io, input logic [ID_B-1:0] id,
                               input logic [PRN_B-1:0] prn, input logic rdy);
    inst_id         = id;
    raw_instr       = instOf(id);
    instr_pc        = pcOf(id);
    prn_input_valid = 3'b001;
    prn_input_ready = {2'b00, rdy};
    prn_input[0]    = prn;
    prn_input[1]    = 6'd63;
    prn_input[2]    = 6'd0;
    prn_output[0]   = dstOf(id);
    prn_output[1]   = 6'd0;
    prn_output[2]   = 6'd0;
    if (io) inst_valid_io = 1'b1;
    else    inst_valid    = 1'b1;
    step();
    inst_valid    = 1'b0;
    inst_valid_io = 1'b0;
  endtask

  // Scoreboard monitor: every issue pulse must match the next expectation.
  always @(negedge clk) begin
    exp_t e;
    if (issue_valid === 1'b1) begin
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("[TB] FAIL ooo_issue unexpected actual_id=%0d required=none", issue_inst_id);
      end else begin
        e = sbq.pop_front();
        if (issue_inst_id !== e.id || issue_inst !== e.inst || issue_pc !== e.pc ||
            issue_op[0] !== e.op0 || issue_out_prn[0] !== e.dst0) begin
          failures++;
          $display("[TB] FAIL ooo_issue actual id=%0d pc=%0h op0=%0h dst=%0d inst=%0h required id=%0d pc=%0h op0=%0h dst=%0d inst=%0h",
                   issue_inst_id, issue_pc, issue_op[0], issue_out_prn[0], issue_inst,
                   e.id, e.pc, e.op0, e.dst0, e.inst);
        end
      end
    end
    if (issue_valid_io === 1'b1) begin
      checks++;
      if (sbq_io.size() == 0) begin
        failures++;
        $display("[TB] FAIL io_issue unexpected actual_id=%0d required=none", issue_inst_id_io);
      end else begin
        e = sbq_io.pop_front();
        if (issue_inst_id_io !== e.id || issue_inst_io !== e.inst || issue_pc_io !== e.pc ||
            issue_op_io[0] !== e.op0 || issue_out_prn_io[0] !== e.dst0) begin
          failures++;
          $display("[TB] FAIL io_issue actual id=%0d pc=%0h op0=%0h required id=%0d pc=%0h op0=%0h",
                   issue_inst_id_io, issue_pc_io, issue_op_io[0], e.id, e.pc, e.op0);
        end
      end
    end
  end

  initial begin
    rst             = 1'b1;
    inst_valid      = 1'b0;
    inst_valid_io   = 1'b0;
    fu_ready        = 1'b0;
    fu_ready_io     = 1'b0;
    flush           = 1'b0;
    inst_id         = '0;
    raw_instr       = '0;
    instr_pc        = '0;
    prn_input_valid = '0;
    prn_input_ready = '0;
    prn_input       = '0;
    prn_output      = '0;
    wb_valid        = '0;
    wb_prn          = '0;

    // Reset / idle
    step();
    step();
    rst = 1'b0;
    checkOutput("rst_queue_ready", queue_ready, 1);
    checkOutput("rst_occupancy", occupancy, 0);
    checkOutput("rst_issue_valid", issue_valid, 0);
    checkOutput("rst_prf_read_enable", prf_read_enable, 0);
    checkOutput("rst_io_queue_ready", queue_ready_io, 1);
    checkOutput("rst_io_issue_valid", issue_valid_io, 0);

    // Oldest-first: A waits on prn 5, B and C ready; expected order B, A, C
    applyStimulus(0, 6'd1, 6'd5, 1'b0);
    applyStimulus(0, 6'd2, 6'd10, 1'b1);
    applyStimulus(0, 6'd3, 6'd11, 1'b1);
    checkOutput("of_occupancy3", occupancy, 3);
    checkOutput("of_sel_enable", prf_read_enable, 3'b001);
    checkOutput("of_sel_prn", prf_read_prn[0], 10);
    expectIssue(0, 6'd2, 6'd10);
    expectIssue(0, 6'd1, 6'd5);
    expectIssue(0, 6'd3, 6'd11);
    wb_valid  = 4'b0001;
    wb_prn[0] = 6'd5;
    fu_ready  = 1'b1;
    step();
    wb_valid = '0;
    checkOutput("of_first_issue", issue_valid, 1);
    step();
    step();
    step();
    checkOutput("of_drained_occ", occupancy, 0);
    checkOutput("of_drained_valid", issue_valid, 0);

    // Insert bypass through port 2
    wb_valid  = 4'b0100;
    wb_prn[2] = 6'd9;
    expectIssue(0, 6'd4, 6'd9);
    applyStimulus(0, 6'd4, 6'd9, 1'b0);
    wb_valid = '0;
    checkOutput("byp_not_early", issue_valid, 0);
    step();
    checkOutput("byp_issue_2cyc", issue_valid, 1);
    step();
    checkOutput("byp_occ", occupancy, 0);

    // Plain wakeup through port 3, one cycle to fire
    applyStimulus(0, 6'd5, 6'd12, 1'b0);
    step();
    checkOutput("wk_waiting", issue_valid, 0);
    checkOutput("wk_occ1", occupancy, 1);
    expectIssue(0, 6'd5, 6'd12);
    wb_valid  = 4'b1000;
    wb_prn[3] = 6'd12;
    step();
    wb_valid = '0;
    checkOutput("wk_not_same_edge", issue_valid, 0);
    step();
    checkOutput("wk_issue", issue_valid, 1);
    step();
    checkOutput("wk_occ0", occupancy, 0);

    // Full queue with simultaneous issue and insert attempt
    fu_ready = 1'b0;
    for (int i = 0; i < QS; i++) begin
      applyStimulus(0, 6'(8 + i), 6'(20 + i), 1'b1);
    end
    checkOutput("full_queue_ready", queue_ready, 0);
    checkOutput("full_occupancy", occupancy, 8);
    expectIssue(0, 6'd8, 6'd20);
    expectIssue(0, 6'd9, 6'd21);
    expectIssue(0, 6'd10, 6'd22);
    fu_ready = 1'b1;
    applyStimulus(0, 6'd30, 6'd40, 1'b1);
    checkOutput("full_after_queue_ready", queue_ready, 1);
    checkOutput("full_after_occ7", occupancy, 7);
    checkOutput("full_after_issue", issue_valid, 1);
    step();
    step();
    checkOutput("pre_flush_occ5", occupancy, 5);

    // Flush with an issue firing the same cycle
    flush = 1'b1;
    step();
    flush = 1'b0;
    checkOutput("flush_issue_valid", issue_valid, 0);
    checkOutput("flush_occ", occupancy, 0);
    checkOutput("flush_queue_ready", queue_ready, 1);
    expectIssue(0, 6'd40, 6'd33);
    applyStimulus(0, 6'd40, 6'd33, 1'b1);
    step();
    checkOutput("post_flush_issue", issue_valid, 1);
    step();
    checkOutput("post_flush_occ", occupancy, 0);
    fu_ready = 1'b0;

    // In-order instance: younger ready entry must wait for the oldest
    applyStimulus(1, 6'd50, 6'd60, 1'b0);
    applyStimulus(1, 6'd51, 6'd61, 1'b1);
    fu_ready_io = 1'b1;
    step();
    step();
    checkOutput("io_blocked_issue", issue_valid_io, 0);
    checkOutput("io_blocked_enable", prf_read_enable_io, 0);
    checkOutput("io_occ2", occupancy_io, 2);
    expectIssue(1, 6'd50, 6'd60);
    expectIssue(1, 6'd51, 6'd61);
    wb_valid  = 4'b0001;
    wb_prn[0] = 6'd60;
    step();
    wb_valid = '0;
    checkOutput("io_wake_edge", issue_valid_io, 0);
    step();
    checkOutput("io_issue_first", issue_valid_io, 1);
    step();
    checkOutput("io_issue_second", issue_valid_io, 1);
    step();
    checkOutput("io_occ0", occupancy_io, 0);
    fu_ready_io = 1'b0;

    step();
    step();
    checkOutput("sb_empty", 64'(sbq.size()), 0);
    checkOutput("sb_io_empty", 64'(sbq_io.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/age_issue_queue.md
# age_issue_queue

Parametrised out-of-order issue queue sitting between the renamer and one functional unit. It accepts one renamed instruction per cycle and wakes operands from any writeback broadcast, including broadcasts in the insert cycle. It selects the oldest ready entry via an age matrix, or strict program order when `IN_ORDER=1`. It reads operands from the PRF, supports a full pipeline flush, and reports occupancy.

## Interface
- `INST_ID_BITS`, 6, instruction tag width
- `PRN_BITS`, 6, physical register number width
- `MAX_OPERANDS`, 3, source and destination operand slots per instruction
- `QUEUE_SIZE`, 8, entry count; any value ≥2, power of 2 not required
- `WB_PORTS`, 4, number of wakeup broadcast ports
- `IN_ORDER`, 0, 1 = only the oldest valid entry is eligible for issue
- `clk` in 1: clock; single clock domain
- `rst` in 1: synchronous, active-high reset
- `inst_valid` in 1: insert request
- `queue_ready` out 1: a free entry exists
- `inst_id` in INST_ID_BITS; `raw_instr` in 32; `instr_pc` in 64
- `prn_input_valid`, `prn_input_ready` in [MAX_OPERANDS]×1; `prn_input` in [MAX_OPERANDS]×PRN_BITS
- `prn_output` in [MAX_OPERANDS]×PRN_BITS
- `wb_valid` in [WB_PORTS]×1; `wb_prn` in [WB_PORTS]×PRN_BITS: wakeup broadcasts
- `flush` in 1: discard all entries and any pending issue
- `fu_ready` in 1: FU can accept an instruction this cycle
- `prf_read_enable` out [MAX_OPERANDS]×1; `prf_read_prn` out [MAX_OPERANDS]×PRN_BITS
- `prf_op` in [MAX_OPERANDS]×64: combinational PRF read data
- `issue_valid` out 1; `issue_inst_id`, `issue_inst`, `issue_pc`, `issue_op[]`, `issue_out_prn[]`: registered FU payload
- `occupancy` out $clog2(QUEUE_SIZE+1): count of valid entries

## Operation
- Entry fields: valid, inst_id, inst, pc, op_valid, op_ready, op_prn, out_prn.
- An entry is ready when it is valid and `op_ready | ~op_valid` is all ones.
- **Insert** fires on `inst_valid && queue_ready && !flush`. The entry goes to the lowest-index free slot.
  - op_ready[j] = prn_input_ready[j] OR (any k with wb_valid[k] && wb_prn[k]==prn_input[j]).
- **Wakeup:** any valid entry operand j with op_valid[j] and op_prn[j]==wb_prn[k] for any k with wb_valid[k] sets op_ready[j]. Matching is across all ports and all operands; no positional pairing.
- **Age matrix:** older[i][j]=1 means entry i is older than entry j.
  - On insert to slot s: row s cleared, column s set to the current valid vector.
  - Freed slots are treated as invalid; their stale bits are ignored.
- **Select:**
  - `IN_ORDER=0`: issue the ready entry that no other ready entry is older than.
  - `IN_ORDER=1`: issue the oldest valid entry only if it is ready; otherwise no issue.
- **Issue** fires on `fu_ready && has_ready && !flush`.
  - `prf_read_enable[j] = op_valid[j]` of the selected entry; the address comes from op_prn. Enables are 0 when nothing is selected.
  - `prf_op` is sampled at the fire edge. The entry is freed at the same edge.
- **Flush:** clears all valid bits at the next edge and forces `issue_valid=0` next cycle. The age matrix need not be cleared.
- **Reset values:** all entries invalid, `issue_valid=0`, all issue payload 0, `occupancy=0`, `queue_ready=1`.

## Timing
- Insert to earliest issue fire is 1 cycle: the entry is selectable the cycle after insert.
- Wakeup to issue fire is 1 cycle. A bypassed insert is also selectable the next cycle.
- Issue fire at edge N gives `issue_valid=1` during cycle N+1 with the registered payload. `issue_valid` is a one-cycle pulse per fire; back-to-back fires give consecutive pulses.
- `queue_ready` and `occupancy` reflect current-cycle state only.
  - A slot freed by issue in cycle N is insertable in cycle N+1.
  - When full, a simultaneous issue does not enable a same-cycle insert.
- `occupancy` next value = current + insert − issue. Insert and issue in the same cycle leave it unchanged.
- Flush has priority over insert, issue and wakeup. Flush together with rst behaves as rst.
- Reset mid-operation discards everything in one cycle; `issue_valid` is 0 the following cycle.
- An operand woken in the same cycle the entry issues has no effect.

## Structure
- Shared package `iq_pkg` holds `iq_entry_t`, parameterised by localparam defaults, and the helper function `entry_ready()`.
- Sub-module `iq_age_matrix`, parameterised by QUEUE_SIZE:
  - Inputs: valid vector, insert enable and slot, request vector.
  - Outputs: one-hot oldest grant and has-grant.
  - It serves both modes. For IN_ORDER the request vector is valid, and the grant is qualified with ready.

## Test plan
- **Reset/idle:** assert rst 2 cycles → `queue_ready=1`, `occupancy=0`, `issue_valid=0`, `prf_read_enable` all 0.
- **Oldest-first:** insert A(id 1, op prn 5 not ready), then B(id 2, all ready) and C(id 3, all ready). Broadcast prn 5; hold fu_ready=1 → issue order B, A, C. Check payload `issue_op` equals `prf_op` at the fire edge.
- **Insert bypass:** insert id 4 with prn_input_ready=0 and prn 9 while wb_valid[2]=1, wb_prn[2]=9 → `issue_valid` asserted 2 cycles after insert.
- **Full plus simultaneous:** fill 8 entries → `queue_ready=0`. Issue plus insert attempt in the same cycle → insert refused; next cycle `queue_ready=1`, `occupancy=7`.
- **IN_ORDER=1:** oldest entry not ready, younger entry ready → no issue until the oldest wakes, then issue in program order.
- **Flush:** 5 entries present with an issue firing the same cycle as flush → `issue_valid=0` next cycle, `occupancy=0`, then a new insert issues normally.
